// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
// Optional statistics counters are enabled with FIFO_RD_STATS_EN.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } rdState_t;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry FIFO-ordered {last, data} buffer; entry 0 is always the head.
// Built without FIFO_RD_STATS_EN dependence.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head_data,
    output logic          head_last
);

    logic [DW-1:0] data0, data1;
    logic          last0, last1;

    assign head_data = data0;
    assign head_last = last0;

    // The head shifts forward on pop so the output always reads slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    occ   <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) begin
                        data0 <= push_data;
                        last0 <= push_last;
                        occ   <= 2'd1;
                    end else if (occ == 2'd1) begin
                        data1 <= push_data;
                        last1 <= push_last;
                        occ   <= 2'(BUF_DEPTH);
                    end
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port drain engine: pops words, absorbs read latency in a skid buffer and
// emits a valid/ready stream framed every BURST_LEN words. FIFO_RD_STATS_EN adds counters.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BURST_LEN = 16
) (
    input  logic          rdClk,
    input  logic          rdRst,
    input  logic          enable,
    input  logic          fifoEmpty,
    output logic          fifoRdEn,
    input  logic [DW-1:0] fifoRdData,
    output logic          outValid,
    input  logic          outReady,
    output logic [DW-1:0] outData,
    output logic          outLast,
    output logic          busy
`ifdef FIFO_RD_STATS_EN
    ,
    input  logic          clearStats,
    output logic [31:0]   wordCount,
    output logic [15:0]   burstCount
`endif
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    rdState_t         state, state_next;
    logic             state_allows;
    logic             inflight, inflight_last;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       occ;
    logic [2:0]       level;
    logic             pop;
    logic             cnt_at_last;

    assign pop         = outValid & outReady;
    assign cnt_at_last = (burst_cnt == CNT_W'(BURST_LEN - 1));
    // Words held or arriving after this edge; popping this cycle frees a slot immediately.
    assign level       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifoRdEn    = !rdRst & !fifoEmpty & (level < 3'(BUF_DEPTH)) & state_allows;
    assign outValid    = (occ != 2'd0);
    assign busy        = (state != IDLE);

    always_ff @(posedge rdClk) begin
        if (rdRst) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            burst_cnt     <= '0;
        end else begin
            state         <= state_next;
            inflight      <= fifoRdEn;
            inflight_last <= fifoRdEn & cnt_at_last;
            if (fifoRdEn)
                burst_cnt <= cnt_at_last ? '0 : burst_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        state_allows = 1'b0;
        case (state)
            IDLE: begin
                if (enable)
                    state_next = RUN;
            end
            RUN: begin
                state_allows = 1'b1;
                if (!enable)
                    state_next = FINISH;
            end
            FINISH: begin
                // Only the partially issued burst is completed.
                state_allows = (burst_cnt != '0);
                if ((burst_cnt == '0) && (occ == 2'd0) && !inflight)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    fifo_rd_skid_buf #(.DW(DW)) u_buf (
        .clk       (rdClk),
        .rst       (rdRst),
        .push      (inflight),
        .push_data (fifoRdData),
        .push_last (inflight_last),
        .pop       (pop),
        .occ       (occ),
        .head_data (outData),
        .head_last (outLast)
    );

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge rdClk) begin
        if (rdRst || clearStats) begin
            wordCount  <= '0;
            burstCount <= '0;
        end else begin
            if (pop)
                wordCount <= wordCount + 32'd1;
            if (pop && outLast)
                burstCount <= burstCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream with a queue-based FIFO and an ordered stream scoreboard.
// Stats checks are compiled in when FIFO_RD_STATS_EN is defined.
module tb_fifo_rd_stream;

    localparam int DW = 32;
    localparam int BL = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } ent_t;

    logic          rdClk;
    logic          rdRst;
    logic          enable;
    logic          fifoEmpty;
    logic          fifoRdEn;
    logic [DW-1:0] fifoRdData;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] outData;
    logic          outLast;
    logic          busy;
`ifdef FIFO_RD_STATS_EN
    logic          clearStats;
    logic [31:0]   wordCount;
    logic [15:0]   burstCount;
`endif

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    ent_t          got_q[$];
    int            rd_cyc_q[$];
    int            val_cyc_q[$];

    int            checks;
    int            errors;
    int            cyc;
    int            issue_cnt;
    logic          rd_now;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    assign fifoEmpty = (fifo_q.size() == 0);

    fifo_rd_stream #(.DW(DW), .BURST_LEN(BL)) dut (
        .rdClk      (rdClk),
        .rdRst      (rdRst),
        .enable     (enable),
        .fifoEmpty  (fifoEmpty),
        .fifoRdEn   (fifoRdEn),
        .fifoRdData (fifoRdData),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .outLast    (outLast),
        .busy       (busy)
`ifdef FIFO_RD_STATS_EN
        ,
        .clearStats (clearStats),
        .wordCount  (wordCount),
        .burstCount (burstCount)
`endif
    );

    initial rdClk = 1'b0;
    always #5 rdClk = ~rdClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check at the falling edge, then update the FIFO/stream model after the rising edge.
    task automatic tick();
        logic       rst_now;
        logic       pop;
        logic [DW:0] e;
        logic [DW-1:0] w;
        @(negedge rdClk);
        cyc++;
        rst_now = rdRst;
        pop     = outValid & outReady;
        if (rst_now) begin
            if (fifoRdEn) chk("rden_in_reset", fifoRdEn, 0);
        end else begin
            if (fifoRdEn) begin
                chk("rden_while_empty", fifoEmpty, 0);
                chk("rden_overfill", (exp_q.size() - int'(pop)) < 2, 1);
                rd_cyc_q.push_back(cyc);
            end
            if (outValid) begin
                chk("valid_without_word", exp_q.size() > 0, 1);
                val_cyc_q.push_back(cyc);
            end
            if (prev_stall) begin
                chk("stall_valid", outValid, 1);
                chk("stall_data", outData, prev_data);
                chk("stall_last", outLast, prev_last);
            end
            if (pop && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stream_data", outData, e[DW-1:0]);
                chk("stream_last", outLast, e[DW]);
                got_q.push_back('{data: outData, last: outLast, cyc: cyc});
            end
        end
        rd_now     = fifoRdEn & !rst_now;
        prev_stall = !rst_now & outValid & !outReady;
        prev_data  = outData;
        prev_last  = outLast;
        @(posedge rdClk);
        if (rst_now) begin
            exp_q.delete();
            issue_cnt = 0;
        end
        #1;
        if (rd_now && fifo_q.size() > 0) begin
            w          = fifo_q.pop_front();
            fifoRdData = w;
            exp_q.push_back({(issue_cnt == BL - 1), w});
            issue_cnt  = (issue_cnt + 1) % BL;
        end
    endtask

    task automatic do_reset();
        rdRst    = 1'b1;
        enable   = 1'b0;
        outReady = 1'b0;
        tick();
        tick();
        rdRst = 1'b0;
        fifo_q.delete();
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    endtask

    task automatic wait_pops(input int target, input int budget);
        int t;
        t = 0;
        while (got_q.size() < target && t < budget) begin
            tick();
            t++;
        end
        chk("pop_timeout", got_q.size() >= target, 1);
    endtask

    initial begin
        int gb, rb, vb, loaded, t;
        checks = 0; errors = 0; cyc = 0; issue_cnt = 0;
        rd_now = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        fifoRdData = '0; outReady = 0; enable = 0; rdRst = 0;
`ifdef FIFO_RD_STATS_EN
        clearStats = 1'b0;
`endif

        // Reset held with enable high.
        rdRst = 1'b1; enable = 1'b1;
        tick(); tick();
        chk("rst_valid", outValid, 0);
        chk("rst_data", outData, 0);
        chk("rst_last", outLast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rden", fifoRdEn, 0);

        // Streaming 8 words with outReady high.
        do_reset();
        gb = got_q.size(); rb = rd_cyc_q.size(); vb = val_cyc_q.size();
        load(8, 32'h1000_0000);
        enable = 1'b1; outReady = 1'b1;
        wait_pops(gb + 8, 60);
        if (got_q.size() >= gb + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("stream8_data", got_q[gb+i].data, 32'h1000_0000 + i);
                chk("stream8_last", got_q[gb+i].last, (i == 3 || i == 7));
            end
            chk("stream8_b2b", got_q[gb+7].cyc - got_q[gb].cyc, 7);
            chk("first_latency", val_cyc_q[vb] - rd_cyc_q[rb], 2);
        end

        // Backpressure with alternating outReady.
        do_reset();
        gb = got_q.size();
        load(8, 32'h2000_0000);
        enable = 1'b1;
        t = 0;
        while (got_q.size() < gb + 8 && t < 80) begin
            outReady = t[0];
            tick();
            t++;
        end
        chk("bp_count", got_q.size() - gb, 8);
        if (got_q.size() >= gb + 8)
            for (int i = 0; i < 8; i++) chk("bp_data", got_q[gb+i].data, 32'h2000_0000 + i);

        // FIFO runs empty mid-burst.
        do_reset();
        gb = got_q.size(); rb = rd_cyc_q.size();
        load(2, 32'h3000_0000);
        enable = 1'b1; outReady = 1'b1;
        wait_pops(gb + 2, 30);
        for (int i = 0; i < 6; i++) tick();
        chk("empty_rd_count", rd_cyc_q.size() - rb, 2);
        load(2, 32'h3000_0002);
        wait_pops(gb + 4, 30);
        if (got_q.size() >= gb + 4) begin
            chk("empty_last1", got_q[gb+1].last, 0);
            chk("empty_last3", got_q[gb+3].last, 1);
            chk("empty_data3", got_q[gb+3].data, 32'h3000_0003);
        end

        // Enable dropped after the second issue.
        do_reset();
        gb = got_q.size(); rb = rd_cyc_q.size();
        load(8, 32'h4000_0000);
        enable = 1'b1; outReady = 1'b1;
        t = 0;
        while (rd_cyc_q.size() - rb < 2 && t < 20) begin
            tick();
            t++;
        end
        enable = 1'b0;
        tick();
        chk("finish_busy", busy, 1);
        for (int i = 0; i < 20; i++) tick();
        chk("finish_rd_count", rd_cyc_q.size() - rb, 4);
        chk("finish_pops", got_q.size() - gb, 4);
        chk("finish_idle", busy, 0);
        chk("finish_fifo_left", fifo_q.size(), 4);
        if (got_q.size() >= gb + 4) chk("finish_last4", got_q[gb+3].last, 1);

        // Reset with two words buffered.
        do_reset();
        gb = got_q.size();
        load(8, 32'h5000_0000);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_valid", outValid, 1);
        chk("pre_rst_held", exp_q.size(), 2);
        rdRst = 1'b1;
        tick();
        rdRst = 1'b0;
        chk("mid_rst_valid", outValid, 0);
        chk("mid_rst_data", outData, 0);
        chk("mid_rst_busy", busy, 0);
`ifdef FIFO_RD_STATS_EN
        chk("mid_rst_wordcount", wordCount, 0);
`endif
        outReady = 1'b1;
        wait_pops(gb + 5, 40);
        outReady = 1'b0;
        if (got_q.size() >= gb + 5) begin
            chk("post_rst_first", got_q[gb].data, 32'h5000_0002);
            chk("post_rst_last", got_q[gb+3].last, 1);
            chk("post_rst_last_data", got_q[gb+3].data, 32'h5000_0005);
        end
`ifdef FIFO_RD_STATS_EN
        chk("stats_words5", wordCount, 5);
        chk("stats_bursts1", burstCount, 1);
        clearStats = 1'b1; outReady = 1'b1;
        tick();
        clearStats = 1'b0; outReady = 1'b0;
        chk("stats_clear_words", wordCount, 0);
        chk("stats_clear_bursts", burstCount, 0);
`endif

        // Randomized traffic, enable and backpressure, then drain.
        do_reset();
        gb = got_q.size();
        loaded = 0;
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) begin
                fifo_q.push_back($urandom);
                loaded++;
            end
            outReady = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 9) != 0);
            tick();
        end
        enable = 1'b1; outReady = 1'b1;
        t = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || rd_now) && t < 200) begin
            tick();
            t++;
        end
        chk("rand_drain_timeout", t < 200, 1);
        chk("rand_word_count", got_q.size() - gb, loaded);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
